uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Byte-stream packet decoder sitting directly downstream of `uart_interface`. It consumes `rx_data`/`rx_valid` and frames packets as sync, opcode, length, payload and checksum. Payload bytes are written into a host buffer port, and validated commands go to the TPU control FSM over a valid/ready handshake. Each packet is answered with one ACK/NAK byte through the UART transmitter (`tx_data`/`tx_start`/`tx_busy`).

## Interface
- `MAX_LEN`, 16: maximum payload bytes per packet (1..255).
- `ADDR_W`, 4: payload write-address width; must satisfy 2^ADDR_W ≥ MAX_LEN.
- `TIMEOUT_CYCLES`, 100000: maximum idle clocks between bytes inside a packet.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte from UART.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid.
- `tx_data`  out  8  response byte to UART.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  UART transmitter busy.
- `wr_en`  out  1  payload byte write strobe.
- `wr_addr`  out  ADDR_W  payload index, 0-based per packet.
- `wr_data`  out  8  payload byte.
- `cmd_valid`  out  1  validated command available.
- `cmd_opcode`  out  8  opcode of the validated command.
- `cmd_len`  out  8  payload length of the validated command.
- `cmd_ready`  in  1  consumer accepts the command.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_len`  out  1  one-cycle pulse: LEN > MAX_LEN.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout.
- `err_overrun`  out  1  one-cycle pulse: byte dropped while busy.

## Operation
- Frame format: `0xAA`, OPC, LEN, LEN payload bytes, CHK.
  - CHK = XOR of OPC, LEN and all payload bytes.
  - With LEN = 0, CHK follows LEN directly.
- States: IDLE, OPC, LEN, DATA, CHK, HOLD, RESP, WAIT_TX.
- IDLE: any byte other than `0xAA` is discarded silently. `0xAA` → OPC.
- OPC: latch the opcode and seed the checksum with it → LEN.
- LEN: latch LEN and XOR it into the checksum.
  - LEN > MAX_LEN → pulse `err_len`, load NAK, go to RESP.
  - LEN = 0 → CHK.
  - Otherwise → DATA, with the index cleared to 0.
- DATA: each byte drives `wr_en`=1, `wr_addr`=index, `wr_data`=byte; XOR it into the checksum and increment the index. After the byte with index LEN−1 → CHK.
- CHK:
  - Received byte equals computed checksum → HOLD, with `cmd_valid`=1 and `cmd_opcode`/`cmd_len` stable.
  - Mismatch → pulse `err_chk`, load NAK (`0x15`), go to RESP. `cmd_valid` is not raised.
- HOLD: remain until `cmd_valid && cmd_ready`, then load ACK (`0x06`) and go to RESP.
- RESP: when `tx_busy`=0, drive `tx_start`=1 for one cycle with `tx_data` loaded → WAIT_TX.
- WAIT_TX: wait until `tx_busy` has been seen high and then low → IDLE. `tx_data` holds its value until the next response.
- Any `rx_valid` in HOLD, RESP or WAIT_TX: drop the byte and pulse `err_overrun`.
- `wr_en` is never asserted outside DATA.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset mid-packet or mid-response aborts immediately; no response byte is sent.
- `wr_en`/`wr_addr`/`wr_data` are registered and appear the cycle after the payload byte's `rx_valid`.
- `cmd_valid` rises the cycle after the CHK byte's `rx_valid`. It falls the cycle after the `cmd_ready` handshake.
- `cmd_ready` asserted while `cmd_valid`=0 is ignored.
- `tx_start` rises no earlier than the cycle after entering RESP. It is never asserted while `tx_busy`=1.
- Every `err_*` pulse lasts exactly one cycle, in the cycle after the triggering byte's `rx_valid`.
- The checksum is an 8-bit XOR; no carries.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - In OPC, LEN, DATA and CHK, a counter resets on every `rx_valid`.
  - When the counter reaches TIMEOUT_CYCLES without a byte: pulse `err_timeout`, go to IDLE, send no response.
- `UART_CMD_TIMEOUT_EN` undefined: no counter logic; `err_timeout` is tied to 0; the decoder waits indefinitely.

## Test plan
- `AA 01 02 11 22 30`, `cmd_ready`=1 → writes (0,`0x11`),(1,`0x22`); `cmd_valid` with opcode `0x01`, len 2; `tx_data`=`0x06`, one `tx_start`.
- `AA 01 02 11 22 31` → `err_chk` pulse; no `cmd_valid`; `tx_data`=`0x15`.
- `AA 05 11` with MAX_LEN=16 → `err_len` pulse; NAK `0x15`; no `wr_en`; the next valid packet decodes normally.
- `55 AA 07 00 07`, `cmd_ready` held 0 for 50 cycles → `0x55` ignored; `cmd_valid` held 50 cycles, len 0; ACK only after `cmd_ready`. A byte sent during HOLD → `err_overrun`.
- With `UART_CMD_TIMEOUT_EN` and TIMEOUT_CYCLES=1000: `AA 01`, then silence → `err_timeout` after 1000 idle cycles; no `tx_start`; state returns to IDLE.
- `rst` asserted during the DATA byte at index 1 → all outputs 0 next cycle; no ACK/NAK; a subsequent full packet decodes correctly.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Byte-stream packet decoder: AA, OPC, LEN, payload, XOR checksum -> payload writes, command handshake, ACK/NAK reply.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder #(
    parameter int MAX_LEN        = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_opcode,
    output logic [7:0]        cmd_len,
    input  logic              cmd_ready,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun
);
    localparam logic [7:0] SYNC      = 8'hAA;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || (1 << ADDR_W) < MAX_LEN || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("uart_cmd_decoder: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, OPC, LEN, DATA, CHK, HOLD, RESP, WAIT_TX} state_t;

    state_t     state;
    logic [7:0] opc_r;
    logic [7:0] len_r;
    logic [7:0] sum;
    logic [7:0] idx;
    logic [7:0] resp;
    logic       seen_busy;
    logic       busy_state;

    assign busy_state = (state == HOLD) || (state == RESP) || (state == WAIT_TX);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;
    logic             in_pkt;

    assign in_pkt = (state == OPC) || (state == LEN) || (state == DATA) || (state == CHK);
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            opc_r       <= '0;
            len_r       <= '0;
            sum         <= '0;
            idx         <= '0;
            resp        <= '0;
            seen_busy   <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= '0;
            cmd_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
            idle_cnt    <= '0;
`endif
        end else begin
            wr_en       <= 1'b0;
            tx_start    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= rx_valid && busy_state;
`ifdef UART_CMD_TIMEOUT_EN
            err_timeout <= 1'b0;
            if (rx_valid || !in_pkt)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
`endif
            case (state)
                IDLE: if (rx_valid && rx_data == SYNC) state <= OPC;
                OPC: if (rx_valid) begin
                    opc_r <= rx_data;
                    sum   <= rx_data;
                    state <= LEN;
                end
                LEN: if (rx_valid) begin
                    len_r <= rx_data;
                    sum   <= sum ^ rx_data;
                    idx   <= '0;
                    if (rx_data > MAX_LEN_B) begin
                        err_len <= 1'b1;
                        resp    <= NAK;
                        state   <= RESP;
                    end else if (rx_data == 8'd0) begin
                        state <= CHK;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (rx_valid) begin
                    wr_en   <= 1'b1;
                    wr_addr <= idx[ADDR_W-1:0];
                    wr_data <= rx_data;
                    sum     <= sum ^ rx_data;
                    idx     <= idx + 8'd1;
                    if (idx + 8'd1 == len_r) state <= CHK;
                end
                CHK: if (rx_valid) begin
                    if (rx_data == sum) begin
                        cmd_valid  <= 1'b1;
                        cmd_opcode <= opc_r;
                        cmd_len    <= len_r;
                        state      <= HOLD;
                    end else begin
                        err_chk <= 1'b1;
                        resp    <= NAK;
                        state   <= RESP;
                    end
                end
                HOLD: if (cmd_valid && cmd_ready) begin
                    cmd_valid <= 1'b0;
                    resp      <= ACK;
                    state     <= RESP;
                end
                RESP: if (!tx_busy) begin
                    tx_start  <= 1'b1;
                    tx_data   <= resp;
                    seen_busy <= 1'b0;
                    state     <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Transmitter may take a cycle to raise busy; only a high-then-low sequence ends the reply.
                    if (tx_busy) seen_busy <= 1'b1;
                    else if (seen_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            if (in_pkt && !rx_valid && idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_timeout <= 1'b1;
                state       <= IDLE;
            end
`endif
        end
    end
endmodule
